ext_bus_arbiter: RTL

//  Shares the single external memory bus between the data-memory stage (MEM) and the program-fetch stage (IF).

---
 rtl/ext_bus_pkg.sv | 19 +
 rtl/bus_wait_counter.sv | 27 ++
 rtl/ext_bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared encodings for the external bus arbiter: FSM states, bus owner codes,
// write/read codes and the wait-counter width helper.
package ext_bus_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   localparam logic OWN_DATA = 1'b0;
   localparam logic OWN_PROG = 1'b1;

   localparam logic BUS_RD = 1'b0;
   localparam logic BUS_WR = 1'b1;

   // WAIT_CYCLES = 0 still needs a 1-bit counter.
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with a zero flag; it times how long bus_cs is held.
module bus_wait_counter #(
   parameter int CNT_W = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ext_bus_arbiter.sv
// Arbitrates the external memory bus between the data stage and instruction fetch.
// Define EXT_READY_EN to add the bus_rdy port and stretch accesses until the device is ready.
module ext_bus_arbiter
   import ext_bus_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   input  logic              p_req,
   input  logic [ADDR_W-1:0] p_addr,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_ack,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_cs,
   output logic              bus_wr_rd,
`ifdef EXT_READY_EN
   input  logic              bus_rdy,
`endif
   output logic              stall,
   output logic              owner
);

   localparam int               CNT_W    = cnt_width(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;
   logic              r_bus_cs;
   logic              r_bus_wr_rd;
   logic              r_owner;
   logic [DATA_W-1:0] r_d_rdata;
   logic [DATA_W-1:0] r_p_rdata;
   logic              r_d_ack;
   logic              r_p_ack;

   logic w_idle;
   logic w_d_elig;
   logic w_p_elig;
   logic w_grant_d;
   logic w_grant_p;
   logic w_grant;
   logic w_cnt_zero;
   logic w_rdy;
   logic w_done;

`ifdef EXT_READY_EN
   assign w_rdy = bus_rdy;
`else
   assign w_rdy = 1'b1;
`endif

   // A port whose ack is high this cycle is masked, which forces alternation
   // when both stages keep requesting.
   assign w_idle    = (r_state == ST_IDLE);
   assign w_d_elig  = d_req & ~r_d_ack;
   assign w_p_elig  = p_req & ~r_p_ack;
   assign w_grant_d = w_idle & w_d_elig;
   assign w_grant_p = w_idle & ~w_d_elig & w_p_elig;
   assign w_grant   = w_grant_d | w_grant_p;
   assign w_done    = (r_state == ST_ACCESS) & w_cnt_zero & w_rdy;

   bus_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait_cnt (
      .CLK        (CLK),
      .RST        (RST),
      .i_load     (w_grant),
      .i_load_val (LOAD_VAL),
      .i_dec      (r_state == ST_ACCESS),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state     <= ST_IDLE;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_cs    <= 1'b0;
         r_bus_wr_rd <= BUS_RD;
         r_owner     <= OWN_DATA;
         r_d_rdata   <= '0;
         r_p_rdata   <= '0;
         r_d_ack     <= 1'b0;
         r_p_ack     <= 1'b0;
      end else begin
         r_d_ack <= 1'b0;
         r_p_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_state  <= ST_ACCESS;
                  r_bus_cs <= 1'b1;
                  if (w_grant_d) begin
                     r_owner     <= OWN_DATA;
                     r_bus_addr  <= d_addr;
                     r_bus_wdata <= d_wdata;
                     r_bus_wr_rd <= d_wr ? BUS_WR : BUS_RD;
                  end else begin
                     r_owner     <= OWN_PROG;
                     r_bus_addr  <= p_addr;
                     r_bus_wr_rd <= BUS_RD;
                  end
               end
            end
            ST_ACCESS: begin
               // Address, data and strobe hold until the access closes.
               if (w_done) begin
                  if (r_owner == OWN_DATA) begin
                     r_d_ack <= 1'b1;
                     if (r_bus_wr_rd == BUS_RD) begin
                        r_d_rdata <= bus_rdata;
                     end
                  end else begin
                     r_p_ack <= 1'b1;
                     if (r_bus_wr_rd == BUS_RD) begin
                        r_p_rdata <= bus_rdata;
                     end
                  end
                  r_bus_cs    <= 1'b0;
                  r_bus_wr_rd <= BUS_RD;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign stall     = w_d_elig | w_p_elig;
   assign d_rdata   = r_d_rdata;
   assign d_ack     = r_d_ack;
   assign p_rdata   = r_p_rdata;
   assign p_ack     = r_p_ack;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_cs    = r_bus_cs;
   assign bus_wr_rd = r_bus_wr_rd;
   assign owner     = r_owner;

endmodule
